// File: rtl/guess_feedback_if.sv
// Player-side signal bundle for the guess feedback controller.
// The master drives the guess and the buttons, and the slave returns the LED and game status.
interface guess_feedback_if #(
  parameter int DATA_W    = 4,
  parameter int MAX_TRIES = 8
);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  logic [DATA_W-1:0] player_guess;
  logic [DATA_W-1:0] bram_data;
  logic              guess_submitted;
  logic              new_game;

  logic              led_correct;
  logic              led_wrong;
  logic              led_higher;
  logic              led_lower;
  logic [TRY_W-1:0]  tries_used;
  logic              game_won;
  logic              game_over;
  logic              busy;

  modport master (
    output player_guess, bram_data, guess_submitted, new_game,
    input  led_correct, led_wrong, led_higher, led_lower,
    input  tries_used, game_won, game_over, busy
  );

  modport slave (
    input  player_guess, bram_data, guess_submitted, new_game,
    output led_correct, led_wrong, led_higher, led_lower,
    output tries_used, game_won, game_over, busy
  );
endinterface

// File: rtl/guess_feedback_ctrl.sv
// Guess feedback controller: it compares each submitted guess with the target and drives the LEDs.
// It also holds wrong-guess indications for a set time and tracks attempts until a new game starts.
//
// state      | meaning
// ST_PLAYING | waiting for a submission
// ST_SHOW    | wrong-guess indication held, submissions ignored
// ST_WON     | correct guess seen, frozen until new_game
// ST_LOST    | attempt limit reached, frozen until new_game
module guess_feedback_ctrl #(
  parameter int DATA_W      = 4,
  parameter int MAX_TRIES   = 8,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic            clk,
  input  logic            rst,
  guess_feedback_if.slave gf
);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_PLAYING = 2'd0,
    ST_SHOW    = 2'd1,
    ST_WON     = 2'd2,
    ST_LOST    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              sub_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TRY_W-1:0]  tries_q, tries_d;
  logic              led_correct_q, led_correct_d;
  logic              led_wrong_q, led_wrong_d;
  logic              led_higher_q, led_higher_d;
  logic              led_lower_q, led_lower_d;
  logic              game_won_q, game_won_d;
  logic              game_over_q, game_over_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] guess_s;
  logic [DATA_W-1:0] target_s;
  logic              submit_evt;
  logic              guess_eq;
  logic              target_gt;
  logic              target_lt;
  logic              last_try;
  logic              hold_done;

  assign guess_s    = gf.player_guess;
  assign target_s   = gf.bram_data;
  assign submit_evt = gf.guess_submitted & ~sub_q;
  assign guess_eq   = (guess_s == target_s);
  assign target_gt  = (target_s > guess_s);
  assign target_lt  = (target_s < guess_s);
  assign last_try   = ((tries_q + TRY_W'(1)) == TRY_LAST);
  assign hold_done  = (cnt_q == CNT_LAST);

  // The edge detector keeps tracking through new_game, so a press held across it yields no event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_PLAYING;
      sub_q         <= 1'b0;
      cnt_q         <= '0;
      tries_q       <= '0;
      led_correct_q <= 1'b0;
      led_wrong_q   <= 1'b0;
      led_higher_q  <= 1'b0;
      led_lower_q   <= 1'b0;
      game_won_q    <= 1'b0;
      game_over_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sub_q         <= gf.guess_submitted;
      cnt_q         <= cnt_d;
      tries_q       <= tries_d;
      led_correct_q <= led_correct_d;
      led_wrong_q   <= led_wrong_d;
      led_higher_q  <= led_higher_d;
      led_lower_q   <= led_lower_d;
      game_won_q    <= game_won_d;
      game_over_q   <= game_over_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tries_d = tries_q;
    if (gf.new_game) begin
      state_d = ST_PLAYING;
      cnt_d   = '0;
      tries_d = '0;
    end else begin
      unique case (state_q)
        ST_PLAYING: begin
          if (submit_evt) begin
            tries_d = tries_q + TRY_W'(1);
            if (guess_eq) begin
              state_d = ST_WON;
            end else if (last_try) begin
              state_d = ST_LOST;
            end else begin
              state_d = ST_SHOW;
              cnt_d   = '0;
            end
          end
        end
        ST_SHOW: begin
          if (hold_done) begin
            state_d = ST_PLAYING;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // LEDs hold their value unless the current state explicitly changes them.
  always_comb begin
    led_correct_d = led_correct_q;
    led_wrong_d   = led_wrong_q;
    led_higher_d  = led_higher_q;
    led_lower_d   = led_lower_q;
    if (gf.new_game) begin
      led_correct_d = 1'b0;
      led_wrong_d   = 1'b0;
      led_higher_d  = 1'b0;
      led_lower_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_PLAYING: begin
          led_correct_d = 1'b0;
          led_wrong_d   = 1'b0;
          led_higher_d  = 1'b0;
          led_lower_d   = 1'b0;
          if (submit_evt) begin
            if (guess_eq) begin
              led_correct_d = 1'b1;
            end else begin
              led_wrong_d  = 1'b1;
              led_higher_d = target_gt;
              led_lower_d  = target_lt;
            end
          end
        end
        ST_SHOW: begin
          if (hold_done) begin
            led_correct_d = 1'b0;
            led_wrong_d   = 1'b0;
            led_higher_d  = 1'b0;
            led_lower_d   = 1'b0;
          end
        end
        default: begin
          led_correct_d = led_correct_q;
        end
      endcase
    end
    game_won_d  = (state_d == ST_WON);
    game_over_d = (state_d == ST_WON) || (state_d == ST_LOST);
    busy_d      = (state_d == ST_SHOW);
  end

  assign gf.led_correct = led_correct_q;
  assign gf.led_wrong   = led_wrong_q;
  assign gf.led_higher  = led_higher_q;
  assign gf.led_lower   = led_lower_q;
  assign gf.tries_used  = tries_q;
  assign gf.game_won    = game_won_q;
  assign gf.game_over   = game_over_q;
  assign gf.busy        = busy_q;
endmodule

// File: tb/tb_guess_feedback_ctrl.sv
// Bench for guess_feedback_ctrl: directed game scenarios followed by random play.
// Every output is compared each cycle against a game-level reference model.
module tb_guess_feedback_ctrl;
  localparam int DATA_W      = 4;
  localparam int MAX_TRIES   = 3;
  localparam int HOLD_CYCLES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  guess_feedback_if #(.DATA_W(DATA_W), .MAX_TRIES(MAX_TRIES)) gif ();

  guess_feedback_ctrl #(
    .DATA_W(DATA_W), .MAX_TRIES(MAX_TRIES), .HOLD_CYCLES(HOLD_CYCLES)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .gf (gif.slave)
  );

  always #5 clk = ~clk;

  // Game-level reference: result 0=in play, 1=won, 2=lost; hold_left = remaining display cycles.
  int m_correct, m_wrong, m_higher, m_lower, m_tries, m_result, m_hold_left;
  bit m_prev_sub;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_correct = 0; m_wrong = 0; m_higher = 0; m_lower = 0;
    m_tries = 0; m_result = 0; m_hold_left = 0;
  endtask

  task automatic model_step(input bit r, input bit ng, input bit sub, input int g, input int b);
    bit evt;
    if (r) begin
      model_clear();
      m_prev_sub = 1'b0;
      return;
    end
    evt = sub && !m_prev_sub;
    m_prev_sub = sub;
    if (ng) begin
      model_clear();
    end else if (m_result != 0) begin
      // frozen
    end else if (m_hold_left > 0) begin
      m_hold_left--;
      if (m_hold_left == 0) begin
        m_correct = 0; m_wrong = 0; m_higher = 0; m_lower = 0;
      end
    end else begin
      m_correct = 0; m_wrong = 0; m_higher = 0; m_lower = 0;
      if (evt) begin
        m_tries++;
        if (g == b) begin
          m_correct = 1;
          m_result  = 1;
        end else begin
          m_wrong  = 1;
          m_higher = (b > g) ? 1 : 0;
          m_lower  = (b < g) ? 1 : 0;
          if (m_tries == MAX_TRIES) m_result = 2;
          else m_hold_left = HOLD_CYCLES;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("led_correct", 32'(gif.led_correct), 32'(m_correct));
    chk("led_wrong",   32'(gif.led_wrong),   32'(m_wrong));
    chk("led_higher",  32'(gif.led_higher),  32'(m_higher));
    chk("led_lower",   32'(gif.led_lower),   32'(m_lower));
    chk("tries_used",  32'(gif.tries_used),  32'(m_tries));
    chk("game_won",    32'(gif.game_won),    32'(m_result == 1));
    chk("game_over",   32'(gif.game_over),   32'(m_result != 0));
    chk("busy",        32'(gif.busy),        32'(m_hold_left > 0));
  endtask

  task automatic step(input bit r, input bit ng, input bit sub, input int g, input int b);
    rst                 = r;
    gif.new_game        = ng;
    gif.guess_submitted = sub;
    gif.player_guess    = DATA_W'(g);
    gif.bram_data       = DATA_W'(b);
    @(posedge clk);
    model_step(r, ng, sub, g, b);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n, input int g, input int b);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, g, b);
  endtask

  task automatic press(input int g, input int b);
    step(1'b0, 1'b0, 1'b1, g, b);
    step(1'b0, 1'b0, 1'b0, g, b);
  endtask

  task automatic new_game_pulse();
    step(1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    int busy_len;
    bit sub_r;
    model_clear();
    m_prev_sub          = 1'b0;
    gif.new_game        = 1'b0;
    gif.guess_submitted = 1'b0;
    gif.player_guess    = '0;
    gif.bram_data       = '0;

    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    idle(10, 0, 0);

    // Correct guess, then extra presses must be ignored.
    press(9, 9);
    press(9, 9);
    press(4, 9);
    chk("won_tries", 32'(gif.tries_used), 32'd1);
    chk("won_flag", 32'(gif.game_won), 32'd1);
    new_game_pulse();

    // Wrong-guess hold length and hint direction.
    step(1'b0, 1'b0, 1'b1, 3, 9);
    busy_len = 0;
    if (gif.busy) busy_len++;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b0, 3, 9);
      if (gif.busy) busy_len++;
    end
    chk("busy_len", 32'(busy_len), 32'(HOLD_CYCLES));
    press(12, 9);
    chk("hint_lower", 32'(gif.led_lower), 32'd1);
    idle(5, 12, 9);
    new_game_pulse();

    // Exhaust the attempt limit.
    press(5, 9);  idle(5, 5, 9);
    press(1, 9);  idle(5, 1, 9);
    press(15, 9); idle(3, 15, 9);
    chk("lost_tries", 32'(gif.tries_used), 32'(MAX_TRIES));
    chk("lost_lower", 32'(gif.led_lower), 32'd1);
    chk("lost_won", 32'(gif.game_won), 32'd0);
    new_game_pulse();

    // A long press counts once; a press while busy is dropped.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 2, 9);
    step(1'b0, 1'b0, 1'b0, 2, 9);
    chk("hold_one_evt", 32'(gif.tries_used), 32'd1);
    idle(5, 2, 9);
    press(2, 9);
    press(2, 9);
    chk("busy_discard", 32'(gif.tries_used), 32'd2);
    idle(5, 2, 9);
    new_game_pulse();

    // new_game beats a simultaneous press; reset aborts a hold.
    step(1'b0, 1'b1, 1'b1, 2, 9);
    step(1'b0, 1'b0, 1'b1, 2, 9);
    step(1'b0, 1'b0, 1'b0, 2, 9);
    chk("ng_drop", 32'(gif.tries_used), 32'd0);
    press(2, 9);
    step(1'b1, 1'b0, 1'b0, 2, 9);
    chk("rst_busy", 32'(gif.busy), 32'd0);
    chk("rst_wrong", 32'(gif.led_wrong), 32'd0);
    idle(2, 2, 9);

    // Random play with small value range so matches happen often.
    sub_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) sub_r = ~sub_r;
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0), sub_r,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
